// File: rtl/i_decode_q.sv
// Registered instruction decode queue between fetch and buffer: decodes RV32I
// (plus OP-V when enabled) into a micro-op record and holds DEPTH records.
module i_decode_q #(
  parameter int INST_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int VEC_EN     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_valid,
  input  logic [INST_WIDTH-1:0] inst,
  output logic                  if_vacant,
  input  logic                  ib_vacant,
  output logic                  ib_valid,
  output logic [6:0]            ib_opt,
  output logic [2:0]            ib_funct,
  output logic [6:0]            ib_funct7,
  output logic [5:0]            ib_funct6,
  output logic                  ib_vm,
  output logic [4:0]            ib_rs1,
  output logic [4:0]            ib_rs2,
  output logic [4:0]            ib_rd,
  output logic [DATA_WIDTH-1:0] ib_imm,
  output logic                  ib_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_V     = 7'b1010111;

  typedef struct packed {
    logic                  illegal;
    logic [6:0]            opt;
    logic [2:0]            funct;
    logic [6:0]            funct7;
    logic [5:0]            funct6;
    logic                  vm;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] imm;
  } rec_t;

  rec_t          dec;
  rec_t          mem [DEPTH];
  rec_t          head;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Size casts of signed operands sign-extend the immediates to DATA_WIDTH.
  always_comb begin
    dec     = '0;
    dec.opt = inst[6:0];
    case (inst[6:0])
      OP_B: begin
        dec.rs1   = inst[19:15];
        dec.rs2   = inst[24:20];
        dec.funct = inst[14:12];
        dec.imm   = DATA_WIDTH'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      end
      OP_L, OP_JALR: begin
        dec.rs1   = inst[19:15];
        dec.rd    = inst[11:7];
        dec.funct = inst[14:12];
        dec.imm   = DATA_WIDTH'($signed(inst[31:20]));
      end
      OP_S: begin
        dec.rs1   = inst[19:15];
        dec.rs2   = inst[24:20];
        dec.funct = inst[14:12];
        dec.imm   = DATA_WIDTH'($signed({inst[31:25], inst[11:7]}));
      end
      OP_I: begin
        dec.rs1   = inst[19:15];
        dec.rd    = inst[11:7];
        dec.funct = inst[14:12];
        if (inst[13:12] == 2'b01) begin
          dec.imm    = DATA_WIDTH'(inst[24:20]);
          dec.funct7 = inst[31:25];
        end else begin
          dec.imm = DATA_WIDTH'($signed(inst[31:20]));
        end
      end
      OP_R: begin
        dec.rs1    = inst[19:15];
        dec.rs2    = inst[24:20];
        dec.rd     = inst[11:7];
        dec.funct  = inst[14:12];
        dec.funct7 = inst[31:25];
      end
      OP_LUI, OP_AUIPC: begin
        dec.rd  = inst[11:7];
        dec.imm = DATA_WIDTH'($signed({inst[31:12], 12'b0}));
      end
      OP_JAL: begin
        dec.rd  = inst[11:7];
        dec.imm = DATA_WIDTH'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      end
      OP_V: begin
        if (VEC_EN != 0) begin
          dec.rs1    = inst[19:15];
          dec.rs2    = inst[24:20];
          dec.rd     = inst[11:7];
          dec.funct  = inst[14:12];
          dec.funct6 = inst[31:26];
          dec.vm     = inst[25];
          if (inst[14:12] == 3'b011)
            dec.imm = DATA_WIDTH'($signed(inst[19:15]));
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign push  = inst_valid && !full;
  assign pop   = !empty && ib_vacant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr_reg] <= dec;
        wr_ptr_reg      <= wr_ptr_reg + 1'b1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Outputs come only from registered state; an empty queue presents all zeros.
  assign head       = empty ? '0 : mem[rd_ptr_reg];
  assign if_vacant  = !full;
  assign ib_valid   = !empty;
  assign ib_opt     = head.opt;
  assign ib_funct   = head.funct;
  assign ib_funct7  = head.funct7;
  assign ib_funct6  = head.funct6;
  assign ib_vm      = head.vm;
  assign ib_rs1     = head.rs1;
  assign ib_rs2     = head.rs2;
  assign ib_rd      = head.rd;
  assign ib_imm     = head.imm;
  assign ib_illegal = head.illegal;

endmodule

// File: doc/i_decode_q.md
Name: i_decode_q

Overview:
- Registered successor to the instruction decode stage; sits between i_fetch and i_buffer.
- Decodes full RV32I base opcodes plus the vector OP-V major opcode (when enabled) into a uniform micro-op record.
- Holds decoded records in a DEPTH-entry FIFO with a true valid/vacant handshake on both sides, so fetch never stalls on a single-cycle buffer hiccup.
- Flags illegal opcodes instead of silently zeroing them.

Parameters:
- INST_WIDTH, 32, instruction width; only 32 is supported.
- DATA_WIDTH, 32, immediate width; must be ≥ 32; sign/zero extension fills upper bits.
- DEPTH, 2, FIFO entries; power of two, ≥ 2.
- VEC_EN, 1, 1 = decode OP-V (7'b1010111); 0 = treat OP-V as illegal.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- inst_valid  in  1  fetch offers inst this cycle
- inst  in  INST_WIDTH  raw instruction
- if_vacant  out  1  decode can accept; equals !full, registered-state only, no combinational path from ib_vacant
- ib_vacant  in  1  buffer accepts head record this cycle
- ib_valid  out  1  head record valid (FIFO not empty)
- ib_opt  out  7  opcode inst[6:0]
- ib_funct  out  3  funct3; 0 for LUI/AUIPC/JAL
- ib_funct7  out  7  inst[31:25] for R-type and I-type shifts (funct3 001/101), else 0
- ib_funct6  out  6  inst[31:26] for OP-V, else 0
- ib_vm  out  1  inst[25] for OP-V, else 0
- ib_rs1  out  5  source 1 / vs1
- ib_rs2  out  5  source 2 / vs2
- ib_rd  out  5  destination / vd
- ib_imm  out  DATA_WIDTH  extended immediate
- ib_illegal  out  1  opcode not recognised

Behaviour:
- Push when inst_valid && if_vacant. Pop when ib_valid && ib_vacant.
- Latency: a record accepted at edge N is visible on ib_* after edge N; ib_valid is high in cycle N+1. There is no combinational bypass.
- Occupancy count is $clog2(DEPTH)+1 bits. Read and write pointers wrap modulo DEPTH.
  - Simultaneous push and pop: count unchanged.
  - When full, if_vacant = 0, so no push occurs even if a pop happens that cycle.
  - When empty, a pop cannot occur.
- When empty, ib_valid = 0 and all ib_* fields are driven to 0.
- Async reset:
  - Pointers, count, and storage are cleared.
  - ib_valid = 0, all ib_* = 0, if_vacant = 1 immediately on assertion.
  - In-flight records are discarded.
  - First push is possible on the first edge after rst deasserts.
- Decode table (rs1 = inst[19:15], rs2 = inst[24:20], rd = inst[11:7] where used; unused fields = 0):
  - B 1100011: rs1, rs2, funct3; imm = sext{inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - L 0000011 / JALR 1100111: rs1, rd, funct3; imm = sext inst[31:20].
  - S 0100011: rs1, rs2, funct3; imm = sext{inst[31:25], inst[11:7]}.
  - I 0010011: rs1, rd, funct3.
    - funct3 001/101: imm = zext inst[24:20], funct7 = inst[31:25].
    - Otherwise: imm = sext inst[31:20].
  - R 0110011: rs1, rs2, rd, funct3, funct7; imm = 0.
  - LUI 0110111 / AUIPC 0010111: rd; imm = {inst[31:12], 12'b0}, sign-extended to DATA_WIDTH.
  - JAL 1101111: rd; imm = sext{inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - OP-V 1010111 (VEC_EN = 1): rs1, rs2, rd, funct3, funct6, vm.
    - funct3 011 (OPIVI): imm = sext inst[19:15].
    - Otherwise: imm = 0.
  - Any other opcode: ib_illegal = 1, ib_opt = inst[6:0], all other fields 0. The record is still enqueued.
- inst is sampled only on push; its value at other times is don't-care.

Test Plan:
- Reset mid-stream: fill 2 entries, assert rst for 1 cycle -> ib_valid = 0 and if_vacant = 1 during reset; both entries lost, all ib_* = 0.
- Back-to-back, ib_vacant = 1: push 0x00500093 then 0x002081B3 -> cycle N+1: opt 0010011, rd 1, imm 5; cycle N+2: opt 0110011, rs1 1, rs2 2, rd 3, funct7 0; stream sustained at 1 per cycle.
- Full/backpressure, DEPTH = 2, ib_vacant = 0: push 3 instructions -> if_vacant falls after the 2nd push; 3rd not accepted until one pop; order preserved.
- Immediates: 0xFE000EE3 (beq, imm = -4) -> ib_imm = 0xFFFFFFFC; 0x800000EF (jal) -> ib_imm = 0xFFF00000; 0x123450B7 (lui) -> ib_imm = 0x12345000.
- Shift and vector:
  - 0x4030D093 (srai x1, x1, 3) -> imm 3, funct7 0100000.
  - 0x022FB0D7 (vadd.vi v1, v2, -1, vm = 1) -> funct6 0, vm 1, rs2 2, rd 1, funct3 011, imm 0xFFFFFFFF.
  - With VEC_EN = 0, same inst -> ib_illegal = 1.
- Illegal opcode: 0x0000007F -> record enqueued, ib_illegal = 1, ib_opt = 1111111, other fields 0.
